// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-pass combinational multiplier for all multiply ops.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        neg1_q, neg1_d, neg2_q, neg2_d;
    logic        spec_q, spec_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [31:0] result_q, result_d;

    logic        sgn1_s, sgn2_s, neg1_s, neg2_s;
    logic [31:0] mag1_s, mag2_s;
    logic        special_s;
    logic [31:0] spec_val_s;
    logic [32:0] sum33_s;
    logic [63:0] mul_next_s;
    logic [32:0] r33_s;
    logic [33:0] diff34_s;
    logic [63:0] div_next_s;
    logic [63:0] prod_fix_s;
    logic [31:0] quo_fix_s, rem_fix_s, fin_res_s;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod_s;
    assign fast_prod_s = $signed({neg1_s & 1'b1 & sgn1_s & src1[31], src1})
                       * $signed({sgn2_s & src2[31], src2});
`endif

    // Operand signedness, magnitudes and special-case detection for the op being offered.
    always_comb begin
        sgn1_s = 1'b0;
        sgn2_s = 1'b0;
        case (op)
            3'd1:    begin sgn1_s = 1'b1; sgn2_s = 1'b1; end
            3'd2:    begin sgn1_s = 1'b1; sgn2_s = 1'b0; end
            3'd4,
            3'd6:    begin sgn1_s = 1'b1; sgn2_s = 1'b1; end
            default: begin sgn1_s = 1'b0; sgn2_s = 1'b0; end
        endcase
        neg1_s = sgn1_s & src1[31];
        neg2_s = sgn2_s & src2[31];
        mag1_s = neg1_s ? (32'd0 - src1) : src1;
        mag2_s = neg2_s ? (32'd0 - src2) : src2;
        special_s  = 1'b0;
        spec_val_s = 32'd0;
        if (op[2] && (src2 == 32'd0)) begin
            special_s  = 1'b1;
            spec_val_s = op[1] ? src1 : 32'hFFFF_FFFF;
        end else if (op[2] && !op[0] && (src1 == 32'h8000_0000) && (src2 == 32'hFFFF_FFFF)) begin
            special_s  = 1'b1;
            spec_val_s = op[1] ? 32'd0 : 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
        end else if (!op[2]) begin
            special_s  = 1'b1;
            spec_val_s = (op == 3'd0) ? fast_prod_s[31:0] : fast_prod_s[63:32];
`endif
        end else begin
            special_s  = 1'b0;
            spec_val_s = 32'd0;
        end
    end

    // One radix-2 iteration for each datapath, plus the FIN sign correction.
    always_comb begin
        sum33_s    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        mul_next_s = {sum33_s, acc_q[31:1]};
        r33_s      = acc_q[63:31];
        diff34_s   = {1'b0, r33_s} - {2'b00, b_q};
        div_next_s = diff34_s[33] ? {r33_s[31:0], acc_q[30:0], 1'b0}
                                  : {diff34_s[31:0], acc_q[30:0], 1'b1};
        prod_fix_s = (neg1_q ^ neg2_q) ? (64'd0 - acc_q) : acc_q;
        quo_fix_s  = (neg1_q ^ neg2_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix_s  = neg1_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        fin_res_s  = 32'd0;
        if (spec_q) begin
            fin_res_s = acc_q[31:0];
        end else begin
            case (op_q)
                3'd0:    fin_res_s = prod_fix_s[31:0];
                3'd1,
                3'd2,
                3'd3:    fin_res_s = prod_fix_s[63:32];
                3'd4,
                3'd5:    fin_res_s = quo_fix_s;
                default: fin_res_s = rem_fix_s;
            endcase
        end
    end

    // Control FSM; start is refused while the done pulse is out so back-to-back ops gap by one cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        spec_d   = spec_q;
        acc_d    = acc_q;
        b_d      = b_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !done_q) begin
                        op_d   = op;
                        neg1_d = neg1_s;
                        neg2_d = neg2_s;
                        acc_d  = {32'd0, op[2] ? mag1_s : mag2_s};
                        b_d    = op[2] ? mag2_s : mag1_s;
                        if (special_s) begin
                            spec_d  = 1'b1;
                            acc_d   = {32'd0, spec_val_s};
                            state_d = S_FIN;
                        end else begin
                            spec_d  = 1'b0;
                            cnt_d   = 5'd31;
                            state_d = S_CALC;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_d = op_q[2] ? div_next_s : mul_next_s;
                    if (cnt_q == 5'd0) begin
                        state_d = S_FIN;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                S_FIN: begin
                    result_d = fin_res_s;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE) | done_d;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            spec_q   <= 1'b0;
            acc_q    <= 64'd0;
            b_q      <= 32'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            spec_q   <= spec_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit; latency is counted in rising edges after the start edge.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
        .src1(src1), .src2(src2), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int k;
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy after start: got %b want 1", name, busy); end
        wait_done(k);
        n_vec++;
        if (k != exp_lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", name, k, exp_lat); end
        n_vec++;
        if (result !== exp) begin n_err++; $display("FAIL %s result: got %h want %h", name, result, exp); end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL %s pulse end: got done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            n_err++; $display("FAIL reset: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
    endtask

    task automatic test_mul;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7x-3");
        run_op(3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, MUL_LAT, "mul_lo");
        run_op(3'd3, 32'h1234_5678, 32'h10, 32'h0000_0001, MUL_LAT, "mulhu_small");
    endtask

    task automatic test_mulh;
        run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, "mulh");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT, "mulhsu");
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, MUL_LAT, "mulhu");
    endtask

    task automatic test_div;
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, "div_-7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, "rem_-7/2");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT, "divu_100/7");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT, "remu_100/7");
    endtask

    task automatic test_special;
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_by0");
        run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
    endtask

    task automatic test_kill;
        run_op(3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT, "kill_prior");
        op = 3'd4; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd14) begin
            n_err++; $display("FAIL kill_calc: got busy=%b done=%b result=%h want 0 0 0000000e", busy, done, result);
        end
        run_op(3'd5, 32'd9, 32'd2, 32'd4, DIV_LAT, "after_kill");
        op = 3'd5; src1 = 32'd50; src2 = 32'd5; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL kill_with_start busy: got %b want 0", busy); end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || result !== 32'd4) begin
            n_err++; $display("FAIL kill_with_start hold: got done=%b result=%h want 0 00000004", done, result);
        end
    endtask

    task automatic test_busy_start;
        int k;
        op = 3'd4; src1 = 32'hFFFF_FFF9; src2 = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 3'd5; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        n_vec++;
        if (k != DIV_LAT - 5) begin n_err++; $display("FAIL busy_start latency: got %0d want %0d", k + 5, DIV_LAT); end
        n_vec++;
        if (result !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL busy_start result: got %h want fffffffd", result); end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL busy_start extra op: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int k;
        op = 3'd7; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        op = 3'd5; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b start in done cycle: got busy=%b want 0", busy); end
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL b2b next start: got busy=%b want 1", busy); end
        wait_done(k);
        n_vec++;
        if (k != DIV_LAT || result !== 32'd14) begin
            n_err++; $display("FAIL b2b second op: got lat=%0d result=%h want %0d 0000000e", k, result, DIV_LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        op = 3'd5; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            n_err++; $display("FAIL async_reset: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "after_reset");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_kill();
        test_busy_start();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
